// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES GF(2^8) helpers and iterative-unit FSM states
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gmul09(input logic [7:0] x);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(x)));
        return x8 ^ x;
    endfunction

    function automatic logic [7:0] gmul0b(input logic [7:0] x);
        logic [7:0] x2;
        logic [7:0] x8;
        x2 = xtime(x);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ x;
    endfunction

    function automatic logic [7:0] gmul0d(input logic [7:0] x);
        logic [7:0] x4;
        logic [7:0] x8;
        x4 = xtime(xtime(x));
        x8 = xtime(x4);
        return x8 ^ x4 ^ x;
    endfunction

    function automatic logic [7:0] gmul0e(input logic [7:0] x);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_mix_single_column.sv
// rtl/inv_mix_single_column.sv - combinational InvMixColumns of one 32-bit column
module inv_mix_single_column
    import aes_pkg::*;
(
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);

    // Row 0 lives in the top byte of the column.
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    logic [7:0] w_r0, w_r1, w_r2, w_r3;

    assign w_a0 = i_col[31:24];
    assign w_a1 = i_col[23:16];
    assign w_a2 = i_col[15:8];
    assign w_a3 = i_col[7:0];

    assign w_r0 = gmul0e(w_a0) ^ gmul0b(w_a1) ^ gmul0d(w_a2) ^ gmul09(w_a3);
    assign w_r1 = gmul09(w_a0) ^ gmul0e(w_a1) ^ gmul0b(w_a2) ^ gmul0d(w_a3);
    assign w_r2 = gmul0d(w_a0) ^ gmul09(w_a1) ^ gmul0e(w_a2) ^ gmul0b(w_a3);
    assign w_r3 = gmul0b(w_a0) ^ gmul0d(w_a1) ^ gmul09(w_a2) ^ gmul0e(w_a3);

    assign o_col = {w_r0, w_r1, w_r2, w_r3};

endmodule

// File: rtl/inv_mixcolumns_iter.sv
// rtl/inv_mixcolumns_iter.sv - iterative InvMixColumns, one column per clock
module inv_mixcolumns_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    state_e       r_state;
    state_e       w_next;
    logic [1:0]   r_col_cnt;
    logic [127:0] r_src;
    logic [127:0] r_res;
    logic [31:0]  w_col_in;
    logic [31:0]  w_col_out;
    logic [6:0]   w_col_base;

    assign w_col_base = {r_col_cnt, 5'd0};
    assign w_col_in   = r_src[w_col_base +: 32];

    inv_mix_single_column u_col (
        .i_col (w_col_in),
        .o_col (w_col_out)
    );

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = BUSY;
            end
            BUSY: begin
                if (r_col_cnt == 2'd3) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_col_cnt <= 2'd0;
            r_src     <= 128'h0;
            r_res     <= 128'h0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && in_valid) begin
                r_src     <= state_in;
                r_col_cnt <= 2'd0;
            end
            // Counter parks at 3 on the last column; the next accept clears it.
            if (r_state == BUSY) begin
                r_res[w_col_base +: 32] <= w_col_out;
                if (r_col_cnt != 2'd3) r_col_cnt <= r_col_cnt + 2'd1;
            end
        end
    end

    assign state_out = r_res;

endmodule

// File: doc/inv_mixcolumns_iter.md
# inv_mixcolumns_iter

Iterative AES InvMixColumns unit for the receiver (decryption) datapath. It is the inverse of the sender-side MixColumns stage. It accepts one 128-bit state over a valid/ready handshake and computes one 32-bit column per clock. It returns the transformed state over a second valid/ready handshake. It sits between InvShiftRows/InvSubBytes and AddRoundKey in the iterative AES-256 decryption round.

## Interface
- No parameters. Width is fixed at 128 bits, 4 columns × 4 bytes.
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  state_in holds a state to transform
- in_ready  output  1  block can accept a state; high only in IDLE
- state_in  input  128  input state; column c = bits [c*32+:32], row 0 byte at [c*32+24+:8], row 3 at [c*32+:8]
- out_valid  output  1  state_out holds a finished result
- out_ready  input  1  downstream accepts state_out
- state_out  output  128  result state, same byte layout as state_in

## Operation
- Per column (a0..a3 = rows 0..3), GF(2^8) with polynomial 0x11b:
  - r0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - r1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - r2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - r3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
- Multiplies are built from xtime: x·2 = (x<<1) ^ (x[7] ? 0x1b : 0), all truncated to 8 bits. 09 = 8^1, 0b = 8^2^1, 0d = 8^4^1, 0e = 8^4^2.
- FSM states:
  - IDLE: in_ready=1. On in_valid: capture state_in into src_reg, col_cnt=0, go to BUSY.
  - BUSY: each cycle, write column col_cnt of src_reg, transformed, into res_reg, then col_cnt++. After writing column 3, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Column order is 0,1,2,3, using bit-slice index c. col_cnt is 2 bits and must not wrap while in BUSY.
- state_in is sampled only at the accept edge. Later changes to it have no effect.
- state_out = res_reg. It is held stable while out_valid=1. During BUSY it is undefined to consumers.
- No overlap: a new state cannot be accepted in BUSY or DONE. in_valid is ignored there.
- Reset, in any state including mid-BUSY: next edge gives IDLE, col_cnt=0, src_reg=0, res_reg=0. Any partial result is discarded.
- Reset values: in_ready=1 (IDLE), out_valid=0, state_out=128'h0.

## Timing
- Accept on edge k (in_valid & in_ready).
- Columns 0..3 are written on edges k+1..k+4.
- out_valid=1 from edge k+4 onward.
- Earliest output handshake is edge k+5. in_ready=1 on the following cycle, so the next accept is at k+6 at the earliest. Peak throughput is one state per 6 cycles.
- If out_ready=0, DONE holds indefinitely with state_out unchanged.
- Combinational path per cycle: one column mux, one single-column InvMixColumns, and res_reg write enable. No combinational path from in_valid or out_ready to any output.

## Structure
- Shared package aes_pkg holds:
  - constant AES_POLY = 8'h1b
  - functions xtime, gmul09, gmul0b, gmul0d, gmul0e
  - FSM state enum (IDLE, BUSY, DONE)
  - these functions are reused by the key schedule and the sender MixColumns.
- One sub-module, inv_mix_single_column: combinational, 32-bit in and 32-bit out, implementing r0..r3. It is instantiated once and time-multiplexed by col_cnt.

## Test plan
- Known vector: state_in = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> state_out = 128'hdb135345_f20a225c_01010101_c6c6c6c6, with out_valid rising exactly 4 edges after accept.
- FIPS-197 round column: column d5d5d7d6 -> d4d4d4d5, and 4d7ebdf8 -> 2d26314c, across all four column positions.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Check that state_out is stable, in_ready=0, and a new in_valid is ignored. Release and check one handshake followed by a return to IDLE.
- Input isolation: change state_in on the cycle after accept and check that the result matches the originally captured state.
- Reset mid-BUSY: drop rst_n at the edge after the column 1 write. Check out_valid=0, state_out=0, in_ready=1 next cycle, and that a fresh vector is then processed correctly.
- Round trip: 1000 random states through the sender MixColumns and then this block, back-to-back with random out_ready. Output must equal input every time.
